// File: rtl/instr_fetch_dispatch.sv
// instr_fetch_dispatch: fetches instructions into IR, presents them to the execute FSMs, and handles NOP/HALT/illegal/timeout
module instr_fetch_dispatch #(
  parameter int          ADDR_W    = 8,
  parameter logic [15:0] SUPPORTED = 16'h003E,
  parameter logic [3:0]  HALT_OP   = 4'hF,
  parameter int          TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memRd,
  input  logic              memReady,
  input  logic [15:0]       memData,
  output logic [15:0]       instruction,
  input  logic              done,
  output logic              pcInc,
  output logic              busy,
  output logic              halted,
  output logic              illegalOp,
  output logic              timeoutErr,
  output logic [15:0]       instrCount
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, SKIP, RETIRE, HALT} state_t;
  state_t            state_q, state_d;
  logic [15:0]       ir_q, ir_d, ins_q, ins_d, cnt_q, cnt_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d, pcinc_q, pcinc_d, busy_q, busy_d, halted_q, halted_d;
  logic              ill_q, ill_d, tmo_q, tmo_d;
  logic [3:0]        op;
  logic              expire;
  // next state, IR/timer/count updates, and registered-output values derived from the next state
  always_comb begin
    op       = ir_q[15:12];
    expire   = timer_q == TW'(TIMEOUT - 1);
    state_d  = state_q;
    ir_d     = ir_q;
    timer_d  = timer_q;
    cnt_d    = cnt_q;
    ill_d    = 1'b0;
    tmo_d    = 1'b0;
    case (state_q)
      IDLE:   state_d = start ? FETCH : IDLE;
      FETCH: begin
        ir_d    = memReady ? memData : ir_q;
        state_d = memReady ? DECODE : FETCH;
      end
      DECODE: begin
        state_d = op == HALT_OP ? HALT : (op == 4'd0 || !SUPPORTED[op]) ? SKIP : EXEC;
        ill_d   = op != HALT_OP && op != 4'd0 && !SUPPORTED[op];
        timer_d = '0;
      end
      EXEC: begin
        state_d = (done || expire) ? RETIRE : EXEC;
        cnt_d   = done ? cnt_q + 16'd1 : cnt_q;
        tmo_d   = !done && expire;
        timer_d = (done || expire) ? timer_q : timer_q + TW'(1);
      end
      SKIP: begin
        cnt_d   = cnt_q + 16'(op == 4'd0);
        state_d = RETIRE;
      end
      RETIRE: state_d = FETCH;
      default: state_d = state_q;
    endcase
    rd_d     = state_d == FETCH;
    addr_d   = (state_d == FETCH && state_q != FETCH) ? pc : addr_q;
    ins_d    = state_d == EXEC ? ir_q : '0;
    pcinc_d  = state_d == SKIP;
    busy_d   = state_d != IDLE && state_d != HALT;
    halted_d = state_d == HALT;
  end
  // state and registered outputs, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ir_q     <= '0;
      ins_q    <= '0;
      cnt_q    <= '0;
      timer_q  <= '0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      pcinc_q  <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      ill_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      ins_q    <= ins_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      pcinc_q  <= pcinc_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      ill_q    <= ill_d;
      tmo_q    <= tmo_d;
    end
  end
  assign memAddr     = addr_q;
  assign memRd       = rd_q;
  assign instruction = ins_q;
  assign pcInc       = pcinc_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign illegalOp   = ill_q;
  assign timeoutErr  = tmo_q;
  assign instrCount  = cnt_q;
endmodule

// File: tb/tb_instr_fetch_dispatch.sv
// tb_instr_fetch_dispatch: random and directed instruction streams checked cycle by cycle against a transaction-level trace model
module tb_instr_fetch_dispatch;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, memReady = 1'b0, done = 1'b0;
  logic [7:0]  pc = '0, memAddr;
  logic [15:0] memData = '0, instruction, instrCount;
  logic        memRd, pcInc, busy, halted, illegalOp, timeoutErr;
  int          vectors = 0, miscompares = 0;

  typedef struct { logic start; logic [7:0] pc; logic rdy; logic [15:0] data; logic done; } stim_t;
  typedef struct { logic rd; logic [7:0] addr; logic [15:0] ins; logic pi, b, h, il, tm; logic [15:0] cnt; } exp_t;
  stim_t       sq[$];
  exp_t        eq[$];
  logic [15:0] m_cnt = '0;
  logic [7:0]  m_pc = '0;
  bit          m_idle = 1'b1, fix_pc = 1'b0;

  instr_fetch_dispatch dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .memAddr(memAddr), .memRd(memRd),
    .memReady(memReady), .memData(memData), .instruction(instruction), .done(done),
    .pcInc(pcInc), .busy(busy), .halted(halted), .illegalOp(illegalOp),
    .timeoutErr(timeoutErr), .instrCount(instrCount)
  );

  always #5 clk = ~clk;

  function automatic exp_t ex(input logic rd, input logic [7:0] a, input logic [15:0] ins,
                              input logic pi, input logic b, input logic h, input logic il, input logic tm);
    exp_t e;
    e.rd = rd; e.addr = a; e.ins = ins; e.pi = pi; e.b = b; e.h = h; e.il = il; e.tm = tm; e.cnt = m_cnt;
    return e;
  endfunction

  task automatic push(input logic st, input logic rdy, input logic [15:0] d, input logic dn, input exp_t e);
    stim_t s;
    s.start = st; s.pc = fix_pc ? 8'h00 : 8'($urandom); s.rdy = rdy; s.data = d; s.done = dn;
    sq.push_back(s);
    eq.push_back(e);
    m_pc = s.pc;
  endtask

  // one instruction as seen from outside: l fetch-wait cycles, decode, then exec (done on cycle d) / skip / halt
  task automatic gen(input logic [15:0] w, input int l, input int d);
    logic [7:0] a;
    logic [3:0] op = w[15:12];
    int k;
    bit tmo;
    if (m_idle) begin
      repeat ($urandom_range(0, 2)) push(1'b0, 1'($urandom), 16'($urandom), 1'($urandom), ex(0, 0, 0, 0, 0, 0, 0, 0));
      push(1'b1, 1'($urandom), 16'($urandom), 1'($urandom), ex(0, 0, 0, 0, 0, 0, 0, 0));
      m_idle = 1'b0;
    end
    a = m_pc;
    for (int i = 1; i <= l; i++)
      push(1'($urandom), i == l, i == l ? w : 16'($urandom), 1'($urandom), ex(1, a, 0, 0, 1, 0, 0, 0));
    push(1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), ex(0, 0, 0, 0, 1, 0, 0, 0));
    if (op == 4'hF) begin
      repeat (20) push(1'b1, 1'($urandom), 16'($urandom), 1'($urandom), ex(0, 0, 0, 0, 0, 1, 0, 0));
    end else if (op == 4'd0 || op > 4'd5) begin
      push(1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), ex(0, 0, 0, 1, 1, 0, op != 4'd0, 0));
      if (op == 4'd0) m_cnt = m_cnt + 16'd1;
      push(1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), ex(0, 0, 0, 0, 1, 0, 0, 0));
    end else begin
      k = d <= 16 ? d : 16;
      tmo = d > 16;
      for (int j = 1; j <= k; j++)
        push(1'($urandom), 1'($urandom), 16'($urandom), j == d, ex(0, 0, w, 0, 1, 0, 0, 0));
      if (!tmo) m_cnt = m_cnt + 16'd1;
      push(1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), ex(0, 0, 0, 0, 1, 0, 0, tmo));
    end
  endtask

  // the compare process: apply each queued cycle and check outputs mid-cycle
  task automatic run(input int n);
    int k = n < 0 ? sq.size() : n;
    stim_t s;
    exp_t e;
    repeat (k) begin
      s = sq.pop_front();
      e = eq.pop_front();
      start = s.start; pc = s.pc; memReady = s.rdy; memData = s.data; done = s.done;
      @(negedge clk);
      vectors++;
      if (memRd !== e.rd || (e.rd && memAddr !== e.addr) || instruction !== e.ins || pcInc !== e.pi ||
          busy !== e.b || halted !== e.h || illegalOp !== e.il || timeoutErr !== e.tm || instrCount !== e.cnt) begin
        miscompares++;
        $display("FAIL cycle t=%0t got rd=%b addr=%h ins=%h pcInc=%b busy=%b halted=%b ill=%b tmo=%b cnt=%0d want rd=%b addr=%h ins=%h pcInc=%b busy=%b halted=%b ill=%b tmo=%b cnt=%0d",
                 $time, memRd, memAddr, instruction, pcInc, busy, halted, illegalOp, timeoutErr, instrCount,
                 e.rd, e.addr, e.ins, e.pi, e.b, e.h, e.il, e.tm, e.cnt);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, " memRd"}, 32'(memRd), 0);
    chk({name, " instruction"}, 32'(instruction), 0);
    chk({name, " memAddr"}, 32'(memAddr), 0);
    chk({name, " busy"}, 32'(busy), 0);
    chk({name, " halted"}, 32'(halted), 0);
    chk({name, " pcInc/ill/tmo"}, {29'd0, pcInc, illegalOp, timeoutErr}, 0);
    chk({name, " instrCount"}, 32'(instrCount), 0);
  endtask

  task automatic restart_model();
    sq.delete();
    eq.delete();
    m_cnt = '0;
    m_idle = 1'b1;
    m_pc = pc;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("por");
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    restart_model();
    fix_pc = 1'b1;
    gen(16'h5042, 2, 3);
    fix_pc = 1'b0;
    run(-1);
    chk("count after 5042", 32'(instrCount), 1);
    gen(16'h0000, 1, 0);
    run(-1);
    chk("count after NOP", 32'(instrCount), 2);
    gen(16'hA123, $urandom_range(1, 4), 0);
    run(-1);
    chk("count after illegal", 32'(instrCount), 2);
    gen(16'h1234, 1, 99);
    run(-1);
    chk("count after timeout", 32'(instrCount), 2);
    gen(16'h2000, 1, 16);
    run(-1);
    chk("count after done on last cycle", 32'(instrCount), 3);
    repeat (60) gen({4'($urandom_range(0, 14)), 12'($urandom)}, $urandom_range(1, 4), $urandom_range(1, 20));
    run(-1);
    gen(16'h3001, 4, 5);
    run(2);
    chk("in fetch before reset", 32'(memRd), 1);
    #2 rst = 1'b0;
    #1;
    chk_reset_outs("reset in fetch");
    start = 1'b0;
    rst = 1'b1;
    restart_model();
    gen(16'h4ABC, 1, 20);
    run(sq.size() - 12);
    chk("in exec before reset", 32'(instruction), 32'h4ABC);
    #2 rst = 1'b0;
    #1;
    chk_reset_outs("reset in exec");
    start = 1'b0;
    rst = 1'b1;
    restart_model();
    gen(16'hF000, 2, 0);
    run(-1);
    chk("halted held", {30'd0, halted, busy}, 32'h2);
    chk("halted memRd", 32'(memRd), 0);
    #2 rst = 1'b0;
    #1;
    chk("reset clears halted", 32'(halted), 0);
    start = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("idle after halt reset");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
